// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared pipeline widths and load-type encodings
package mem_wb_stage_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_extender.sv
// rtl/mem_wb_stage_load_extender.sv - load data extraction, sign/zero extension and misalignment detection
module load_extender
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = byte_off[1] ? mem_data[31:16] : mem_data[15:0];
    byte_sel = 8'h00;
    case (byte_off)
      2'd0: byte_sel = mem_data[7:0];
      2'd1: byte_sel = mem_data[15:8];
      2'd2: byte_sel = mem_data[23:16];
      2'd3: byte_sel = mem_data[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  // Illegal load types only matter when the load data is actually selected.
  always_comb begin
    load_data  = mem_data;
    misaligned = 1'b0;
    case (load_type)
      LD_LW: begin
        load_data  = mem_data;
        misaligned = mem_to_reg && (byte_off != 2'd0);
      end
      LD_LH: begin
        load_data  = {{(DATA_W-16){half[15]}}, half};
        misaligned = mem_to_reg && byte_off[0];
      end
      LD_LHU: begin
        load_data  = {{(DATA_W-16){1'b0}}, half};
        misaligned = mem_to_reg && byte_off[0];
      end
      LD_LB:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      default: misaligned = mem_to_reg;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with writeback select and retire counter
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic              i_link,
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_byte_off,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_pc_plus8,
  output logic              write_enable,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              o_misaligned,
  output logic [31:0]       o_retired
);

  logic [DATA_W-1:0] load_data;
  logic              load_misaligned;
  logic [DATA_W-1:0] wb_data;
  logic              bad_access;
  logic              do_write;

  load_extender #(.DATA_W(DATA_W)) u_load_extender (
    .load_type  (i_load_type),
    .byte_off   (i_byte_off),
    .mem_to_reg (i_mem_to_reg),
    .mem_data   (i_mem_data),
    .load_data  (load_data),
    .misaligned (load_misaligned)
  );

  always_comb begin
    if (i_link)
      wb_data = i_pc_plus8;
    else if (i_mem_to_reg)
      wb_data = load_data;
    else
      wb_data = i_alu_result;
    bad_access = i_valid && load_misaligned;
    do_write   = i_valid && i_reg_write && !load_misaligned && (i_wb_addr != '0);
  end

  // Flush leaves address/data stale; write_enable alone qualifies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      o_misaligned <= 1'b0;
      reg_addr     <= '0;
      write_data   <= '0;
      o_retired    <= '0;
    end else if (i_flush) begin
      write_enable <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_stall) begin
      write_enable <= do_write;
      o_misaligned <= bad_access;
      reg_addr     <= i_wb_addr;
      write_data   <= wb_data;
      if (i_valid && (o_retired != 32'hFFFF_FFFF))
        o_retired <= o_retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, valid, stall, flush, reg_write, mem_to_reg, link;
  logic [2:0]  load_type;
  logic [1:0]  byte_off;
  logic [4:0]  wb_addr;
  logic [31:0] alu_result, mem_data, pc_plus8;
  logic        write_enable, o_misaligned;
  logic [4:0]  reg_addr;
  logic [31:0] write_data, o_retired;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic        m_we, m_mis;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  longint      m_ret;

  // register file fed by the stage
  logic [31:0] rf [32];
  int          rf_writes = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg), .i_link(link),
    .i_load_type(load_type), .i_byte_off(byte_off), .i_wb_addr(wb_addr),
    .i_alu_result(alu_result), .i_mem_data(mem_data), .i_pc_plus8(pc_plus8),
    .write_enable(write_enable), .reg_addr(reg_addr), .write_data(write_data),
    .o_misaligned(o_misaligned), .o_retired(o_retired)
  );

  always @(negedge clk) begin
    if (write_enable) begin
      rf[reg_addr] <= write_data;
      rf_writes <= rf_writes + 1;
    end
  end

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  off;
    logic        lnk, m2r, rw;
    logic [4:0]  addr;
    logic [31:0] md, alu, pc8;
    logic        exp_we, exp_mis;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] ref_load(int lt, int off, logic [31:0] md);
    logic [31:0] sh;
    sh = md >> (8 * off);
    case (lt)
      1: return {{16{sh[15]}}, sh[15:0]};
      2: return {16'h0, sh[15:0]};
      3: return {{24{sh[7]}}, sh[7:0]};
      4: return {24'h0, sh[7:0]};
      default: return md;
    endcase
  endfunction

  function automatic logic ref_bad(int lt, int off, logic m2r);
    if (!m2r) return 1'b0;
    if (lt == 0) return off != 0;
    if (lt == 1 || lt == 2) return (off % 2) == 1;
    if (lt > 4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic bad;
    bad = ref_bad(load_type, byte_off, mem_to_reg);
    @(posedge clk);
    if (reset) begin
      m_we = 0; m_mis = 0; m_addr = 0; m_data = 0; m_ret = 0;
    end else if (flush) begin
      m_we = 0; m_mis = 0;
    end else if (!stall) begin
      m_mis  = valid && bad;
      m_we   = valid && reg_write && !bad && wb_addr != 0;
      m_addr = wb_addr;
      m_data = link ? pc_plus8 : (mem_to_reg ? ref_load(load_type, byte_off, mem_data) : alu_result);
      if (valid && m_ret < 64'hFFFF_FFFF) m_ret++;
    end
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".we"}, {31'b0, write_enable}, {31'b0, m_we});
    chk({tag, ".mis"}, {31'b0, o_misaligned}, {31'b0, m_mis});
    chk({tag, ".ret"}, o_retired, m_ret[31:0]);
    if (m_we) begin
      chk({tag, ".addr"}, {27'b0, reg_addr}, {27'b0, m_addr});
      chk({tag, ".data"}, write_data, m_data);
    end
  endtask

  task automatic idle();
    valid = 0; stall = 0; flush = 0; reg_write = 0; mem_to_reg = 0; link = 0;
    load_type = 0; byte_off = 0; wb_addr = 0; alu_result = 0; mem_data = 0; pc_plus8 = 0;
  endtask

  task automatic alu_write(logic [4:0] a, logic [31:0] d);
    idle();
    valid = 1; reg_write = 1; wb_addr = a; alu_result = d;
  endtask

  task automatic randomize_inputs();
    valid = $urandom_range(0, 3) != 0;
    reg_write = $urandom_range(0, 3) != 0;
    mem_to_reg = $urandom_range(0, 1);
    link = $urandom_range(0, 5) == 0;
    load_type = 3'($urandom_range(0, 7));
    byte_off = 2'($urandom_range(0, 3));
    wb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    alu_result = $urandom; mem_data = $urandom; pc_plus8 = $urandom;
  endtask

  initial begin
    longint base;
    vecs[0] = '{3'd3, 2'd1, 0, 1, 1, 5'd3,  32'h0000_8000, 32'h0, 32'h0, 1, 0, 32'hFFFF_FF80};
    vecs[1] = '{3'd2, 2'd2, 0, 1, 1, 5'd5,  32'hBEEF_0000, 32'h0, 32'h0, 1, 0, 32'h0000_BEEF};
    vecs[2] = '{3'd2, 2'd1, 0, 1, 1, 5'd5,  32'hBEEF_0000, 32'h0, 32'h0, 0, 1, 32'h0};
    vecs[3] = '{3'd0, 2'd0, 0, 0, 1, 5'd0,  32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0};
    vecs[4] = '{3'd0, 2'd0, 1, 0, 1, 5'd31, 32'h0, 32'h0000_1234, 32'h0000_0108, 1, 0, 32'h0000_0108};
    vecs[5] = '{3'd0, 2'd0, 0, 1, 1, 5'd7,  32'hCAFE_F00D, 32'h0, 32'h0, 1, 0, 32'hCAFE_F00D};
    vecs[6] = '{3'd1, 2'd0, 0, 1, 1, 5'd8,  32'h0001_8001, 32'h0, 32'h0, 1, 0, 32'hFFFF_8001};
    vecs[7] = '{3'd4, 2'd3, 0, 1, 1, 5'd9,  32'h80AB_1234, 32'h0, 32'h0, 1, 0, 32'h0000_0080};
    vecs[8] = '{3'd5, 2'd0, 0, 1, 1, 5'd10, 32'h1111_2222, 32'h0, 32'h0, 0, 1, 32'h0};
    vecs[9] = '{3'd0, 2'd2, 0, 1, 1, 5'd11, 32'h1111_2222, 32'h0, 32'h0, 0, 1, 32'h0};

    idle();
    reset = 1;
    tick(); tick();
    chk("reset.we", {31'b0, write_enable}, 32'd0);
    chk("reset.mis", {31'b0, o_misaligned}, 32'd0);
    chk("reset.addr", {27'b0, reg_addr}, 32'd0);
    chk("reset.data", write_data, 32'd0);
    chk("reset.ret", o_retired, 32'd0);
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      idle();
      valid = 1; load_type = vecs[i].lt; byte_off = vecs[i].off; link = vecs[i].lnk;
      mem_to_reg = vecs[i].m2r; reg_write = vecs[i].rw; wb_addr = vecs[i].addr;
      mem_data = vecs[i].md; alu_result = vecs[i].alu; pc_plus8 = vecs[i].pc8;
      tick();
      chk($sformatf("vec%0d.we", i), {31'b0, write_enable}, {31'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d.mis", i), {31'b0, o_misaligned}, {31'b0, vecs[i].exp_mis});
      chk($sformatf("vec%0d.ret", i), o_retired, 32'(i + 1));
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d.addr", i), {27'b0, reg_addr}, {27'b0, vecs[i].addr});
        chk($sformatf("vec%0d.data", i), write_data, vecs[i].exp_data);
      end
    end
    idle(); tick();
    chk("mis_pulse_end", {31'b0, o_misaligned}, 32'd0);

    // stall freezes a valid write; stall+flush yields a bubble
    alu_write(5'd4, 32'h0000_0011);
    tick();
    base = m_ret;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(); valid = 1; stall = 1;
      tick();
      chk("stall.we", {31'b0, write_enable}, 32'd1);
      chk("stall.addr", {27'b0, reg_addr}, 32'd4);
      chk("stall.data", write_data, 32'h0000_0011);
      chk("stall.ret", o_retired, base[31:0]);
    end
    stall = 1; flush = 1; valid = 1;
    tick();
    chk("stall_flush.we", {31'b0, write_enable}, 32'd0);
    chk("stall_flush.mis", {31'b0, o_misaligned}, 32'd0);
    chk("stall_flush.ret", o_retired, base[31:0]);

    // register-file round trip
    alu_write(5'd1, 32'hAAAA_BBBB); tick();
    alu_write(5'd2, 32'h1234_5678); tick();
    idle(); tick(); tick();
    chk("rf.r1", rf[1], 32'hAAAA_BBBB);
    chk("rf.r2", rf[2], 32'h1234_5678);

    // reset during a stall discards the held instruction
    alu_write(5'd6, 32'h0000_0066); stall = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; idle();
    tick();
    rf_writes = 0;
    tick(); tick(); tick();
    chk("rst_stall.ret", o_retired, 32'd0);
    chk("rst_stall.writes", 32'(rf_writes), 32'd0);
    chk("rst_stall.we", {31'b0, write_enable}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 49) == 0;
      tick();
      chk_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width; ADDR_W, 5, register address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  MEM-stage slot holds a real instruction.
- i_stall  in  1  hold current WB contents.
- i_flush  in  1  replace next WB contents with a bubble.
- i_reg_write  in  1  instruction writes the register file.
- i_mem_to_reg  in  1  select load data.
- i_link  in  1  select i_pc_plus8 (JAL/JALR).
- i_load_type  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; others illegal.
- i_byte_off  in  2  address bits [1:0] of the load.
- i_wb_addr  in  ADDR_W  destination register.
- i_alu_result, i_mem_data, i_pc_plus8  in  DATA_W  writeback sources.
- write_enable  out  1  register-file write strobe.
- reg_addr  out  ADDR_W  register-file write address.
- write_data  out  DATA_W  register-file write data.
- o_misaligned  out  1  one-cycle exception pulse.
- o_retired  out  32  retired-instruction count.

Function
REQ-003 The block SHALL be one pipeline register; inputs captured at edge N SHALL appear on outputs after edge N, i.e. latency of 1 cycle.
REQ-004 Write data SHALL be selected before the register with priority: i_link -> i_pc_plus8; else i_mem_to_reg -> extended load; else i_alu_result.
REQ-005 Load extension SHALL be: LW -> word; LH/LHU -> halfword at bits [15:0] for off=0 and [31:16] for off=2, sign/zero extended; LB/LBU -> byte at bits [8*off+7:8*off], sign/zero extended.
REQ-006 Misalignment SHALL be: LW with off!=0; LH/LHU with off[0]=1; any illegal i_load_type with i_mem_to_reg=1.
REQ-007 A misaligned load SHALL be captured with its write suppressed, and o_misaligned SHALL be 1 for exactly the cycle it occupies WB.
REQ-008 write_enable SHALL equal registered (valid & reg_write & !misaligned & addr!=0), so writes to register 0 never occur.
REQ-009 When i_stall=1 and i_flush=0, all registered state SHALL hold and o_retired SHALL not change.
REQ-010 When i_flush=1, the next state SHALL be a bubble (write_enable=0, o_misaligned=0) regardless of i_stall; flush wins.
REQ-011 o_retired SHALL increment by 1 on each edge that captures i_valid=1 with i_stall=0 and i_flush=0, including misaligned loads; it SHALL saturate at 0xFFFFFFFF.
REQ-012 reg_addr and write_data MAY hold stale values while write_enable=0; consumers SHALL qualify them by write_enable.

Reset
REQ-013 While reset=1 at an edge, write_enable, o_misaligned, reg_addr, write_data and o_retired SHALL all become 0.
REQ-014 reset SHALL dominate i_stall and i_flush.
REQ-015 A reset mid-stall SHALL discard the held instruction, with no write after reset deasserts.

Structure
REQ-016 The load-type encodings (LW..LBU) and the widths DATA_W/ADDR_W SHALL live in the shared pipeline package used by the decode and MEM stages.
REQ-017 Load extension and misalignment detection SHALL be a combinational sub-module named load_extender; the top holds the register, select mux and counter.

Verification
REQ-018 LB, off=1, mem_data=0x0000_8000, addr=3 -> next cycle write_enable=1, reg_addr=3, write_data=0xFFFF_FF80.
REQ-019 LHU, off=2, mem_data=0xBEEF_0000, addr=5 -> write_data=0x0000_BEEF; the same with off=1 -> write_enable=0, o_misaligned=1 for one cycle, o_retired+1.
REQ-020 ALU write, addr=0, alu_result=0xDEADBEEF -> write_enable=0.
REQ-021 JAL with link=1, pc_plus8=0x0000_0108, addr=31, alu_result=0x1234 -> write_data=0x0000_0108.
REQ-022 Valid ALU write, then i_stall=1 for 3 cycles with changing inputs -> outputs and o_retired frozen; stall+flush together -> write_enable=0.
REQ-023 Connected to the register file: write 0xAAAA_BBBB to r1, then 0x1234_5678 to r2 through this stage -> reads of r1/r2 return those values; reset asserted mid-stall -> o_retired=0 and no further writes.
